bayes_seq_ctrl: RTL and testbench

BAYES_SEQ_CTRL -- requirements
Module: bayes_seq_ctrl

---
 rtl/bayes_pkg.sv | 22 ++
 rtl/seq_down_counter.sv | 32 +++
 rtl/bayes_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bayes_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayes_pkg.sv
// bayes_pkg: shared definitions for the Bayesian inference sequencer.
//   - state_t     : controller state encoding
//   - NARRAY_DEF  : default array address width (2**Narray tiles per side)
//   - NWORD_DEF   : default word address width within a tile
//   - LEN_W_DEF   : default width of the inference-length field
package bayes_pkg;

    localparam int NARRAY_DEF = 2;
    localparam int NWORD_DEF  = 6;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_LOAD,
        ST_WAIT_OBS,
        ST_INFER,
        ST_READ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable unsigned down-counter with a zero flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (wins over dec)
//   load_val   : value loaded on load
//   dec        : decrement by one; holds at zero
//   zero       : count == 0
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bayes_seq_ctrl.sv
// bayes_seq_ctrl: sequences one inference run of the Bayesian array:
// seed, memory load, one inference burst per observation, array read-out.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, abort       : begin a run (IDLE only) / cancel the current run
//   cfg_log            : 0 = stochastic, 1 = logarithmic (latched on start)
//   cfg_nobs, cfg_len  : observation count, cycles per stochastic inference
//   obs_valid, obs_adr : observation handshake input and its row address
//   obs_ready          : observation accepted this cycle
//   load_seed, load_mem, inference, read_1, read_8, read_out : datapath strobes
//   stoch_log          : latched mode
//   adr_full_row/col   : array row / column address
//   busy, done         : run in progress / one-cycle completion pulse
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_IDLE     | waiting for start
// ST_SEED     | load_seed pulse
// ST_LOAD     | load_mem pulse
// ST_WAIT_OBS | obs_ready high, waiting for an observation
// ST_INFER    | inference burst for the accepted observation
// ST_READ     | read-out sweep over the tile columns
// ST_DONE     | done pulse
module bayes_seq_ctrl
    import bayes_pkg::*;
#(
    parameter int Narray = NARRAY_DEF,
    parameter int Nword  = NWORD_DEF,
    parameter int N      = Narray + Nword,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_log,
    input  logic [3:0]       cfg_nobs,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             obs_valid,
    input  logic [N-1:0]     obs_adr,
    output logic             obs_ready,
    output logic             inference,
    output logic             load_seed,
    output logic             read_1,
    output logic             read_8,
    output logic             load_mem,
    output logic             read_out,
    output logic             stoch_log,
    output logic [N-1:0]     adr_full_row,
    output logic [N-1:0]     adr_full_col,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic             obs_xfer;
    logic [LEN_W:0]   cyc_init;
    logic             cyc_zero;
    logic             obs_zero;

    // obs_ready is high exactly while in ST_WAIT_OBS
    assign obs_xfer = (state == ST_WAIT_OBS) && obs_valid;

    // The burst lasts cyc_init+1 cycles: max(len,1) stochastic, 1 logarithmic.
    // The extra counter bit keeps the maximum length from wrapping.
    always_comb begin
        cyc_init = '0;
        if (!stoch_log && (len_q != '0)) begin
            cyc_init = {1'b0, len_q} - 1'b1;
        end
    end

    seq_down_counter #(.W(LEN_W + 1)) u_cyc_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (obs_xfer),
        .load_val (cyc_init),
        .dec      (state == ST_INFER),
        .zero     (cyc_zero)
    );

    // Decremented as the observation is accepted, so during ST_INFER a zero
    // flag means this burst is the last one.
    seq_down_counter #(.W(4)) u_obs_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == ST_IDLE) && start),
        .load_val (cfg_nobs),
        .dec      (obs_xfer),
        .zero     (obs_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            obs_ready    <= 1'b0;
            inference    <= 1'b0;
            load_seed    <= 1'b0;
            read_1       <= 1'b0;
            read_8       <= 1'b0;
            load_mem     <= 1'b0;
            read_out     <= 1'b0;
            stoch_log    <= 1'b0;
            adr_full_row <= '0;
            adr_full_col <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (abort && (state != ST_IDLE)) begin
            state     <= ST_IDLE;
            obs_ready <= 1'b0;
            inference <= 1'b0;
            load_seed <= 1'b0;
            read_1    <= 1'b0;
            read_8    <= 1'b0;
            load_mem  <= 1'b0;
            read_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        stoch_log <= cfg_log;
                        len_q     <= cfg_len;
                        load_seed <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    load_seed <= 1'b0;
                    load_mem  <= 1'b1;
                    state     <= ST_LOAD;
                end
                ST_LOAD: begin
                    load_mem <= 1'b0;
                    if (obs_zero) begin
                        read_out     <= 1'b1;
                        adr_full_col <= '0;
                        state        <= ST_READ;
                    end else begin
                        obs_ready <= 1'b1;
                        state     <= ST_WAIT_OBS;
                    end
                end
                ST_WAIT_OBS: begin
                    if (obs_valid) begin
                        obs_ready    <= 1'b0;
                        adr_full_row <= obs_adr;
                        inference    <= 1'b1;
                        read_1       <= !stoch_log;
                        read_8       <= stoch_log;
                        state        <= ST_INFER;
                    end
                end
                ST_INFER: begin
                    if (cyc_zero) begin
                        inference <= 1'b0;
                        read_1    <= 1'b0;
                        read_8    <= 1'b0;
                        if (obs_zero) begin
                            read_out     <= 1'b1;
                            adr_full_col <= '0;
                            state        <= ST_READ;
                        end else begin
                            obs_ready <= 1'b1;
                            state     <= ST_WAIT_OBS;
                        end
                    end
                end
                ST_READ: begin
                    if (&adr_full_col[N-1:Nword]) begin
                        read_out <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        adr_full_col[N-1:Nword] <= adr_full_col[N-1:Nword] + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bayes_seq_ctrl.sv
// Testbench for bayes_seq_ctrl: a run-level model expands each directed
// scenario into per-cycle expected outputs and input stimulus; a negedge
// process compares every cycle, and literal strobe counts pin the model.
module tb_bayes_seq_ctrl;

    localparam int NA = 2;
    localparam int NW = 6;
    localparam int N  = NA + NW;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_log = 1'b0;
    logic [3:0]    cfg_nobs = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          obs_valid = 1'b0;
    logic [N-1:0]  obs_adr = '0;
    logic          obs_ready, inference, load_seed, read_1, read_8, load_mem, read_out;
    logic          stoch_log, busy, done;
    logic [N-1:0]  adr_full_row, adr_full_col;

    bayes_seq_ctrl #(.Narray(NA), .Nword(NW), .N(N), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_log      (cfg_log),
        .cfg_nobs     (cfg_nobs),
        .cfg_len      (cfg_len),
        .obs_valid    (obs_valid),
        .obs_adr      (obs_adr),
        .obs_ready    (obs_ready),
        .inference    (inference),
        .load_seed    (load_seed),
        .read_1       (read_1),
        .read_8       (read_8),
        .load_mem     (load_mem),
        .read_out     (read_out),
        .stoch_log    (stoch_log),
        .adr_full_row (adr_full_row),
        .adr_full_col (adr_full_col),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         load_seed, load_mem, inference, read_1, read_8, read_out;
        logic         obs_ready, stoch_log, busy, done;
        logic [N-1:0] row, col;
    } snap_t;

    typedef struct packed {
        logic         start, abort, obs_valid;
        logic [N-1:0] adr;
    } stim_t;

    snap_t dut_snap;
    assign dut_snap = {load_seed, load_mem, inference, read_1, read_8, read_out,
                       obs_ready, stoch_log, busy, done, adr_full_row, adr_full_col};

    int vectors = 0;
    int miscompares = 0;
    int cyc_idx = 0;
    string case_name = "reset";
    snap_t cmp_q[$];

    always @(negedge clk) begin
        snap_t e;
        if (cmp_q.size() > 0) begin
            e = cmp_q.pop_front();
            vectors++;
            if (dut_snap !== e) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h want %h", case_name, cyc_idx, dut_snap, e);
            end
        end
    end

    int n_seed, n_load, n_inf, n_r1, n_r8, n_ro, n_rdy, n_done;
    always @(negedge clk) begin
        n_seed += int'(load_seed);
        n_load += int'(load_mem);
        n_inf  += int'(inference);
        n_r1   += int'(read_1);
        n_r8   += int'(read_8);
        n_ro   += int'(read_out);
        n_rdy  += int'(obs_ready);
        n_done += int'(done);
    end

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s %s: got %0d want %0d", case_name, name, got, want);
        end
    endtask

    task automatic check_snap(input string name, input snap_t got, input snap_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s %s: got %h want %h", case_name, name, got, want);
        end
    endtask

    // model state carried between runs: addresses hold across runs
    logic [N-1:0] m_row = '0;
    logic [N-1:0] m_col = '0;
    logic [N-1:0] obs_tab [16];
    int           obs_dly [16];

    function automatic snap_t base(input logic lg, input logic [N-1:0] row, input logic [N-1:0] col);
        snap_t e;
        e = '0;
        e.busy = 1'b1;
        e.stoch_log = lg;
        e.row = row;
        e.col = col;
        return e;
    endfunction

    task automatic run_case(input string name, input logic lg, input int nobs, input int len,
                            input bit noise, input bit hold_start,
                            input int abort_at, input int reset_at);
        snap_t        eq[$];
        stim_t        sq[$];
        snap_t        e;
        stim_t        s_noise, s_quiet, s;
        int           burst;
        logic [N-1:0] row, col;

        case_name = name;
        row = m_row;
        col = m_col;
        burst = lg ? 1 : ((len == 0) ? 1 : len);
        s_noise = '0;
        s_noise.start = hold_start;
        s_noise.obs_valid = noise;
        s_noise.adr = 8'hE7;
        s_quiet = '0;
        s_quiet.start = hold_start;
        s_quiet.adr = 8'h18;

        e = base(lg, row, col); e.load_seed = 1'b1; eq.push_back(e); sq.push_back(s_noise);
        e = base(lg, row, col); e.load_mem = 1'b1;  eq.push_back(e); sq.push_back(s_noise);
        for (int j = 0; j < nobs; j++) begin
            for (int k = 0; k <= obs_dly[j]; k++) begin
                e = base(lg, row, col); e.obs_ready = 1'b1; eq.push_back(e);
                s = s_quiet;
                if (k == obs_dly[j]) begin
                    s.obs_valid = 1'b1;
                    s.adr = obs_tab[j];
                end
                sq.push_back(s);
            end
            row = obs_tab[j];
            for (int k = 0; k < burst; k++) begin
                e = base(lg, row, col);
                e.inference = 1'b1;
                e.read_1 = !lg;
                e.read_8 = lg;
                eq.push_back(e);
                sq.push_back(s_noise);
            end
        end
        for (int k = 0; k < (1 << NA); k++) begin
            col = N'(k << NW);
            e = base(lg, row, col); e.read_out = 1'b1; eq.push_back(e); sq.push_back(s_noise);
        end
        e = base(lg, row, col); e.done = 1'b1; eq.push_back(e);
        s = s_quiet; s.start = 1'b0; sq.push_back(s);

        if (abort_at >= 0) begin
            sq[abort_at].abort = 1'b1;
            while (eq.size() > abort_at + 1) eq.pop_back();
            while (sq.size() > abort_at + 1) sq.pop_back();
            row = eq[abort_at].row;
            col = eq[abort_at].col;
        end
        if (reset_at >= 0) begin
            while (eq.size() > reset_at) eq.pop_back();
            while (sq.size() > reset_at) sq.pop_back();
        end else begin
            e = base(lg, row, col); e.busy = 1'b0; eq.push_back(e);
            sq.push_back('0);
        end

        n_seed = 0; n_load = 0; n_inf = 0; n_r1 = 0;
        n_r8 = 0; n_ro = 0; n_rdy = 0; n_done = 0;
        cfg_log = lg;
        cfg_nobs = 4'(nobs);
        cfg_len = LW'(len);
        start = 1'b1;
        abort = 1'b0;
        obs_valid = 1'b0;
        @(posedge clk); #1;
        // configuration must have been latched; scramble it
        cfg_log = !lg;
        cfg_nobs = ~cfg_nobs;
        cfg_len = ~cfg_len;
        for (int c = 0; c < sq.size(); c++) begin
            cyc_idx = c;
            start = sq[c].start;
            abort = sq[c].abort;
            obs_valid = sq[c].obs_valid;
            obs_adr = sq[c].adr;
            cmp_q.push_back(eq[c]);
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        obs_valid = 1'b0;

        if (reset_at >= 0) begin
            #2 rst_n = 1'b0;
            #1 check_snap("async_reset", dut_snap, '0);
            m_row = '0;
            m_col = '0;
            @(posedge clk); #3;
            rst_n = 1'b1;
        end else begin
            m_row = row;
            m_col = col;
        end
    endtask

    initial begin
        #2 check_snap("reset_state", dut_snap, '0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        obs_tab[0] = 8'h13; obs_dly[0] = 0;
        obs_tab[1] = 8'h2A; obs_dly[1] = 0;
        run_case("stoch_2obs", 1'b0, 2, 4, 1'b0, 1'b0, -1, -1);
        check_int("load_seed_cycles", n_seed, 1);
        check_int("load_mem_cycles", n_load, 1);
        check_int("inference_cycles", n_inf, 8);
        check_int("read_1_cycles", n_r1, 8);
        check_int("read_8_cycles", n_r8, 0);
        check_int("read_out_cycles", n_ro, 4);
        check_int("done_cycles", n_done, 1);
        check_int("obs_ready_cycles", n_rdy, 2);
        check_int("final_row", int'(adr_full_row), 'h2A);
        check_int("final_col", int'(adr_full_col), 'hC0);

        obs_tab[0] = 8'h05; obs_dly[0] = 1;
        obs_tab[1] = 8'h80; obs_dly[1] = 0;
        obs_tab[2] = 8'hFF; obs_dly[2] = 2;
        run_case("log_3obs_noise", 1'b1, 3, 7, 1'b1, 1'b1, -1, -1);
        check_int("inference_cycles", n_inf, 3);
        check_int("read_8_cycles", n_r8, 3);
        check_int("read_1_cycles", n_r1, 0);
        check_int("obs_ready_cycles", n_rdy, 6);
        check_int("done_cycles", n_done, 1);

        run_case("no_obs", 1'b0, 0, 5, 1'b1, 1'b0, -1, -1);
        check_int("obs_ready_cycles", n_rdy, 0);
        check_int("inference_cycles", n_inf, 0);
        check_int("read_out_cycles", n_ro, 4);
        check_int("done_cycles", n_done, 1);

        obs_tab[0] = 8'h77; obs_dly[0] = 10;
        run_case("slow_obs_len0", 1'b0, 1, 0, 1'b0, 1'b0, -1, -1);
        check_int("obs_ready_cycles", n_rdy, 11);
        check_int("inference_cycles", n_inf, 1);

        obs_tab[0] = 8'h3C; obs_dly[0] = 0;
        run_case("abort_infer", 1'b0, 1, 3, 1'b0, 1'b0, 4, -1);
        check_int("done_cycles", n_done, 0);
        check_int("inference_cycles", n_inf, 2);
        check_int("busy_after_abort", int'(busy), 0);

        obs_tab[0] = 8'h5A; obs_dly[0] = 0;
        run_case("rerun_len_max", 1'b0, 1, 255, 1'b0, 1'b0, -1, -1);
        check_int("inference_cycles", n_inf, 255);
        check_int("done_cycles", n_done, 1);

        obs_tab[0] = 8'h9C; obs_dly[0] = 0;
        run_case("reset_mid_read", 1'b0, 1, 2, 1'b0, 1'b0, -1, 6);
        check_int("done_cycles", n_done, 0);

        obs_tab[0] = 8'h41; obs_dly[0] = 0;
        run_case("after_reset", 1'b1, 1, 3, 1'b0, 1'b0, -1, -1);
        check_int("done_cycles", n_done, 1);
        check_int("inference_cycles", n_inf, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
